// File: rtl/wptr_full_lvl_pkg.sv
// Shared types and helpers for the async-FIFO pointer blocks.
// Pointers are ADDRSIZE+1 bits wide: the extra MSB tells full apart from empty.
package wptr_full_lvl_pkg;

  localparam int ADDRSIZE_MAX = 16;
  localparam int PTR_MAX_W    = ADDRSIZE_MAX + 1;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  function automatic int ptr_width(input int addrsize);
    return addrsize + 1;
  endfunction

  function automatic int fifo_depth(input int addrsize);
    return 1 << addrsize;
  endfunction

  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b = '0;
    for (int i = 0; i < PTR_MAX_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_lvl_if.sv
// Write-side bus of the async FIFO pointer block.
// Handshake: winc is the write valid and ~wfull the ready; a word is accepted on a wclk edge where both are high.
interface wptr_full_lvl_if #(
  parameter int ADDRSIZE = 6
);
  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic                afull_ld;
  logic [ADDRSIZE:0]   afull_thresh;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wlevel;
  logic                wovf;

  modport master (
    output winc, wq2_rptr, afull_ld, afull_thresh,
    input  waddr, wptr, wfull, walmost_full, wlevel, wovf
  );

  modport slave (
    input  winc, wq2_rptr, afull_ld, afull_thresh,
    output waddr, wptr, wfull, walmost_full, wlevel, wovf
  );
endinterface

// File: rtl/wptr_full_lvl_gray2bin_ptr.sv
// Combinational Gray-to-binary pointer converter, shared with the read-side block.
module wptr_full_lvl_gray2bin_ptr
  import wptr_full_lvl_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  always_comb begin
    bin_o = WIDTH'(gray2bin(ptr_max_t'(gray_i)));
  end

endmodule

// File: rtl/wptr_full_lvl.sv
// Write-domain pointer, full, fill-level and almost-full generator for the async FIFO.
// Define WPTR_FULL_OVF_EN to build the sticky overflow flag; otherwise wovf is tied low.
module wptr_full_lvl
  import wptr_full_lvl_pkg::*;
#(
  parameter int ADDRSIZE  = 6,
  parameter int AFULL_RST = (1 << ADDRSIZE) - 2
) (
  input  logic           wclk,
  input  logic           wrst,
  wptr_full_lvl_if.slave bus
);

  localparam int PTR_W = ptr_width(ADDRSIZE);
  typedef logic [PTR_W-1:0] ptr_t;
  localparam ptr_t DEPTH = ptr_t'(fifo_depth(ADDRSIZE));

  ptr_t wbin_q,   wbin_d;
  ptr_t wptr_q,   wptr_d;
  ptr_t wlevel_q, wlevel_d;
  ptr_t thr_q,    thr_d;
  logic wfull_q,  wfull_d;
  logic wafull_q, wafull_d;
  logic wen;
  ptr_t rbin;
  ptr_t rptr_full_cmp;

  wptr_full_lvl_gray2bin_ptr #(
    .WIDTH (PTR_W)
  ) u_rptr_g2b (
    .gray_i (bus.wq2_rptr),
    .bin_o  (rbin)
  );

  // Full when the next write pointer sits exactly one lap ahead of the read pointer.
  assign rptr_full_cmp = {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1], bus.wq2_rptr[ADDRSIZE-2:0]};

  always_comb begin
    wen      = bus.winc & ~wfull_q;
    wbin_d   = wbin_q + ptr_t'(wen);
    wptr_d   = ptr_t'(bin2gray(ptr_max_t'(wbin_d)));
    wfull_d  = (wptr_d == rptr_full_cmp);
    wlevel_d = wbin_d - rbin;
    thr_d    = thr_q;
    if (bus.afull_ld) begin
      thr_d = (bus.afull_thresh > DEPTH) ? DEPTH : bus.afull_thresh;
    end
    wafull_d = (wlevel_d >= thr_d);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      thr_q    <= ptr_t'(AFULL_RST);
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      thr_q    <= thr_d;
    end
  end

`ifdef WPTR_FULL_OVF_EN
  logic wovf_q, wovf_d;

  always_comb begin
    wovf_d = wovf_q | (bus.winc & wfull_q);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wovf_q <= 1'b0;
    end else begin
      wovf_q <= wovf_d;
    end
  end

  assign bus.wovf = wovf_q;
`else
  assign bus.wovf = 1'b0;
`endif

  assign bus.waddr        = wbin_q[ADDRSIZE-1:0];
  assign bus.wptr         = wptr_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = wafull_q;
  assign bus.wlevel       = wlevel_q;

endmodule

// File: tb/tb_wptr_full_lvl.sv
// Bench for wptr_full_lvl at ADDRSIZE=4: directed table, corner sequences and random traffic
// checked against a word-count model of the FIFO.
module tb_wptr_full_lvl;

  localparam int A         = 4;
  localparam int DEPTH     = 16;
  localparam int AFULL_RST = DEPTH - 2;

  logic clk = 1'b0;
  logic rst;

  wptr_full_lvl_if #(.ADDRSIZE(A)) bus ();

  wptr_full_lvl #(
    .ADDRSIZE  (A),
    .AFULL_RST (AFULL_RST)
  ) dut (
    .wclk (clk),
    .wrst (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: total words written and total words read (as seen through wq2_rptr).
  int m_wr, m_rd, m_level, m_thr;
  bit m_full, m_afull, m_ovf;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit         winc;
    int         rd_adv;
    int         exp_level;
    bit         exp_full;
    bit         exp_afull;
    logic [A:0] exp_wptr;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [A:0] gray_of(input int n);
    logic [A:0] b;
    b = n[A:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_cycle(input bit winc, input int rd_adv, input bit ld,
                             input int thr_in, input bit do_rst);
    int  rd_next;
    bit  accept;
    int  exp_ovf;
    rd_next          = do_rst ? 0 : m_rd + rd_adv;
    rst              = do_rst;
    bus.winc         = winc;
    bus.wq2_rptr     = gray_of(rd_next);
    bus.afull_ld     = ld;
    bus.afull_thresh = thr_in[A:0];
    @(posedge clk);
    if (do_rst) begin
      m_wr = 0; m_rd = 0; m_level = 0;
      m_full = 0; m_afull = 0; m_ovf = 0;
      m_thr = AFULL_RST;
    end else begin
      if (winc && m_full) m_ovf = 1;
      accept  = winc && !m_full;
      m_wr    = m_wr + int'(accept);
      m_rd    = rd_next;
      m_level = m_wr - m_rd;
      m_full  = (m_level == DEPTH);
      if (ld) m_thr = (thr_in > DEPTH) ? DEPTH : thr_in;
      m_afull = (m_level >= m_thr);
    end
`ifdef WPTR_FULL_OVF_EN
    exp_ovf = int'(m_ovf);
`else
    exp_ovf = 0;
`endif
    #1;
    check("wfull",        int'(bus.wfull),        int'(m_full));
    check("wlevel",       int'(bus.wlevel),       m_level);
    check("walmost_full", int'(bus.walmost_full), int'(m_afull));
    check("wptr",         int'(bus.wptr),         int'(gray_of(m_wr)));
    check("waddr",        int'(bus.waddr),        m_wr % DEPTH);
    check("wovf",         int'(bus.wovf),         exp_ovf);
  endtask

  initial begin
    rst = 1'b1;
    bus.winc = 1'b0; bus.wq2_rptr = '0; bus.afull_ld = 1'b0; bus.afull_thresh = '0;
    m_wr = 0; m_rd = 0; m_level = 0; m_thr = AFULL_RST;
    m_full = 0; m_afull = 0; m_ovf = 0;

    // 16 writes, 3 blocked writes while full, then read pointer jumps to 16.
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{1'b1, 0, i + 1, (i == 15), (i + 1 >= AFULL_RST), gray_of(i + 1)};
    end
    vecs[15].exp_wptr = 5'b11000;
    for (int i = 16; i < 19; i++) vecs[i] = '{1'b1, 0, 16, 1'b1, 1'b1, 5'b11000};
    vecs[19] = '{1'b0, 16, 0, 1'b0, 1'b0, 5'b11000};

    drive_cycle(0, 0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 1);
    check("reset_wptr",  int'(bus.wptr),   0);
    check("reset_level", int'(bus.wlevel), 0);

    for (int i = 0; i < 20; i++) begin
      drive_cycle(vecs[i].winc, vecs[i].rd_adv, 0, 0, 0);
      check($sformatf("vec%0d_level", i), int'(bus.wlevel),       vecs[i].exp_level);
      check($sformatf("vec%0d_full", i),  int'(bus.wfull),        int'(vecs[i].exp_full));
      check($sformatf("vec%0d_afull", i), int'(bus.walmost_full), int'(vecs[i].exp_afull));
      check($sformatf("vec%0d_wptr", i),  int'(bus.wptr),         int'(vecs[i].exp_wptr));
    end
    check("full16_waddr", int'(bus.waddr), 0);

    // Second lap: 16 more writes wrap the binary pointer to 0.
    for (int i = 0; i < 16; i++) drive_cycle(1, 0, 0, 0, 0);
    check("lap2_wptr",  int'(bus.wptr),  0);
    check("lap2_full",  int'(bus.wfull), 1);
    check("lap2_waddr", int'(bus.waddr), 0);

    // Programmed threshold 12.
    drive_cycle(0, 0, 0, 0, 1);
    drive_cycle(0, 0, 1, 12, 0);
    for (int i = 0; i < 11; i++) drive_cycle(1, 0, 0, 0, 0);
    check("thr12_w11_afull", int'(bus.walmost_full), 0);
    drive_cycle(1, 0, 0, 0, 0);
    check("thr12_w12_afull", int'(bus.walmost_full), 1);

    // Threshold load and write on the same edge take effect together.
    drive_cycle(1, 0, 1, 13, 0);
    check("thr13_same_edge_afull", int'(bus.walmost_full), 1);

    // Write and read together at level 15.
    drive_cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(1, 1, 0, 0, 0);
    check("wr_rd_level", int'(bus.wlevel), 15);
    check("wr_rd_full",  int'(bus.wfull),  0);

    // Overflow, drain to level 9, then reset mid-fill.
    drive_cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) drive_cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)  drive_cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++)  drive_cycle(0, 1, 0, 0, 0);
    check("midfill_level", int'(bus.wlevel), 9);
    drive_cycle(1, 0, 0, 0, 1);
    check("midrst_level", int'(bus.wlevel), 0);
    check("midrst_wovf",  int'(bus.wovf),   0);
    for (int i = 0; i < 13; i++) drive_cycle(1, 0, 0, 0, 0);
    check("rst_thr_w13_afull", int'(bus.walmost_full), 0);
    drive_cycle(1, 0, 0, 0, 0);
    check("rst_thr_w14_afull", int'(bus.walmost_full), 1);

    // Threshold 0 and saturating threshold.
    drive_cycle(0, 0, 0, 0, 1);
    drive_cycle(0, 0, 1, 0, 0);
    check("thr0_afull", int'(bus.walmost_full), 1);
    drive_cycle(0, 0, 1, 25, 0);
    for (int i = 0; i < 15; i++) drive_cycle(1, 0, 0, 0, 0);
    check("thrsat_w15_afull", int'(bus.walmost_full), 0);
    drive_cycle(1, 0, 0, 0, 0);
    check("thrsat_w16_afull", int'(bus.walmost_full), 1);
    check("thrsat_w16_full",  int'(bus.wfull),        1);

    // Random traffic against the model.
    drive_cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      bit w, ld;
      int adv, thr;
      w   = ($urandom_range(0, 3) != 0);
      adv = (m_rd < m_wr && $urandom_range(0, 2) != 0) ? 1 : 0;
      ld  = ($urandom_range(0, 19) == 0);
      thr = $urandom_range(0, 20);
      drive_cycle(w, adv, ld, thr, ($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
